// File: rtl/mod9_count_monitor.sv
// rtl/mod9_count_monitor.sv - checker that predicts and verifies a loadable MOD-9 up/down counter
module mod9_count_monitor #(
    parameter int WRAP_W      = 8,
    parameter int ERR_W       = 8,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cnt_rst,
    input  logic              cnt_load,
    input  logic              cnt_control,
    input  logic [3:0]        cnt_I,
    input  logic [3:0]        cnt_q,
    output logic              synced,
    output logic              up_wrap,
    output logic              dn_wrap,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] dn_wraps,
    output logic              err_pulse,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [3:0]        err_exp,
    output logic [3:0]        err_got
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] exp_r;
    logic       up_ctx;
    logic       dn_ctx;
    logic [3:0] q_next;
    logic       cmp_en;
    logic       err_ev;
    logic       up_ev;
    logic       dn_ev;

    // Next-q prediction from the tapped counter inputs and its present q
    always_comb begin
        q_next = 4'd0;
        if (cnt_rst) begin
            q_next = 4'd0;
        end else if (cnt_load && (cnt_I < 4'd9)) begin
            q_next = cnt_I;
        end else if (cnt_control && (cnt_q < 4'd8)) begin
            q_next = cnt_q + 4'd1;
        end else if (cnt_control && (cnt_q == 4'd8)) begin
            q_next = 4'd0;
        end else if (!cnt_control && (cnt_q == 4'd0)) begin
            q_next = 4'd8;
        end else begin
            q_next = cnt_q - 4'd1;
        end
    end

    // Prediction and wrap context always follow the actual q, which resyncs after a mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_r  <= 4'd0;
            up_ctx <= 1'b0;
            dn_ctx <= 1'b0;
        end else begin
            exp_r  <= q_next;
            up_ctx <= (cnt_q == 4'd8) && cnt_control && !cnt_rst && !cnt_load;
            dn_ctx <= (cnt_q == 4'd0) && !cnt_control && !cnt_rst && !cnt_load;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: clr always returns to SYNC; FAULT is left only by clr/rst
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = SYNC;
        end else begin
            case (state)
                SYNC:    state_nx = TRACK;
                TRACK:   state_nx = (err_ev && HALT_ON_ERR) ? FAULT : TRACK;
                FAULT:   state_nx = FAULT;
                default: state_nx = SYNC;
            endcase
        end
    end

    // Output/event decode: compares only in TRACK, and clr suppresses any event that cycle
    always_comb begin
        synced = (state == TRACK);
        cmp_en = (state == TRACK) && !clr;
        err_ev = cmp_en && ((cnt_q != exp_r) || (cnt_q > 4'd8));
        up_ev  = cmp_en && !err_ev && up_ctx && (cnt_q == 4'd0);
        dn_ev  = cmp_en && !err_ev && dn_ctx && (cnt_q == 4'd8);
    end

    // Registered pulses, saturating statistics and first-error capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            up_wrap   <= 1'b0;
            dn_wrap   <= 1'b0;
            up_wraps  <= '0;
            dn_wraps  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            err_exp   <= 4'd0;
            err_got   <= 4'd0;
        end else if (clr) begin
            err_pulse <= 1'b0;
            up_wrap   <= 1'b0;
            dn_wrap   <= 1'b0;
            up_wraps  <= '0;
            dn_wraps  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            err_exp   <= 4'd0;
            err_got   <= 4'd0;
        end else begin
            err_pulse <= err_ev;
            up_wrap   <= up_ev;
            dn_wrap   <= dn_ev;
            if (up_ev && (up_wraps != {WRAP_W{1'b1}})) begin
                up_wraps <= up_wraps + WRAP_W'(1);
            end
            if (dn_ev && (dn_wraps != {WRAP_W{1'b1}})) begin
                dn_wraps <= dn_wraps + WRAP_W'(1);
            end
            if (err_ev) begin
                err <= 1'b1;
                if (!err) begin
                    err_exp <= exp_r;
                    err_got <= cnt_q;
                end
                if (err_cnt != {ERR_W{1'b1}}) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mod9_count_monitor.sv
// tb/tb_mod9_count_monitor.sv - self-checking bench for mod9_count_monitor
module tb_mod9_count_monitor;

    logic       clk = 1'b0;
    logic       rst, clr, cnt_rst, cnt_load, cnt_control;
    logic [3:0] cnt_I, cnt_q;

    logic       a_synced, a_up_wrap, a_dn_wrap, a_err_pulse, a_err;
    logic [7:0] a_up_wraps, a_dn_wraps, a_err_cnt;
    logic [3:0] a_err_exp, a_err_got;

    logic       b_synced, b_up_wrap, b_dn_wrap, b_err_pulse, b_err;
    logic [1:0] b_up_wraps, b_dn_wraps;
    logic [7:0] b_err_cnt;
    logic [3:0] b_err_exp, b_err_got;

    mod9_count_monitor #(.WRAP_W(8), .ERR_W(8), .HALT_ON_ERR(1'b0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cnt_rst(cnt_rst), .cnt_load(cnt_load),
        .cnt_control(cnt_control), .cnt_I(cnt_I), .cnt_q(cnt_q),
        .synced(a_synced), .up_wrap(a_up_wrap), .dn_wrap(a_dn_wrap),
        .up_wraps(a_up_wraps), .dn_wraps(a_dn_wraps), .err_pulse(a_err_pulse),
        .err(a_err), .err_cnt(a_err_cnt), .err_exp(a_err_exp), .err_got(a_err_got)
    );

    mod9_count_monitor #(.WRAP_W(2), .ERR_W(8), .HALT_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst(rst), .clr(clr), .cnt_rst(cnt_rst), .cnt_load(cnt_load),
        .cnt_control(cnt_control), .cnt_I(cnt_I), .cnt_q(cnt_q),
        .synced(b_synced), .up_wrap(b_up_wrap), .dn_wrap(b_dn_wrap),
        .up_wraps(b_up_wraps), .dn_wraps(b_dn_wraps), .err_pulse(b_err_pulse),
        .err(b_err), .err_cnt(b_err_cnt), .err_exp(b_err_exp), .err_got(b_err_got)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cq       = 0;

    // reference model, index 0 = dut, 1 = dut_h; phase 0=sync 1=track 2=fault
    int wmax[2] = '{255, 3};
    int halt[2] = '{0, 1};
    int m_st[2], m_exp[2], m_upc[2], m_dnc[2];
    int m_errp[2], m_upp[2], m_dnp[2], m_upw[2], m_dnw[2];
    int m_err[2], m_ecnt[2], m_eexp[2], m_egot[2];

    function automatic int next_q(int r, int l, int c, int i, int q);
        if (r != 0) return 0;
        if (l != 0 && i < 9) return i;
        if (c != 0) begin
            if (q < 8) return q + 1;
            if (q == 8) return 0;
            return q - 1;
        end
        if (q == 0) return 8;
        return q - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_exp[k] = 0; m_upc[k] = 0; m_dnc[k] = 0;
            m_errp[k] = 0; m_upp[k] = 0; m_dnp[k] = 0; m_upw[k] = 0; m_dnw[k] = 0;
            m_err[k] = 0; m_ecnt[k] = 0; m_eexp[k] = 0; m_egot[k] = 0;
        end
    endtask

    task automatic model_edge();
        int q, r, l, c, i, cl;
        q = int'(cnt_q); r = int'(cnt_rst); l = int'(cnt_load);
        c = int'(cnt_control); i = int'(cnt_I); cl = int'(clr);
        for (int k = 0; k < 2; k++) begin
            bit trk, e, u, d;
            trk = (m_st[k] == 1) && (cl == 0);
            e = trk && (q != m_exp[k] || q > 8);
            u = trk && !e && (m_upc[k] != 0) && q == 0;
            d = trk && !e && (m_dnc[k] != 0) && q == 8;
            if (cl != 0) begin
                m_errp[k] = 0; m_upp[k] = 0; m_dnp[k] = 0; m_upw[k] = 0; m_dnw[k] = 0;
                m_err[k] = 0; m_ecnt[k] = 0; m_eexp[k] = 0; m_egot[k] = 0; m_st[k] = 0;
            end else begin
                m_errp[k] = int'(e); m_upp[k] = int'(u); m_dnp[k] = int'(d);
                if (u && m_upw[k] < wmax[k]) m_upw[k]++;
                if (d && m_dnw[k] < wmax[k]) m_dnw[k]++;
                if (e) begin
                    if (m_err[k] == 0) begin
                        m_eexp[k] = m_exp[k];
                        m_egot[k] = q;
                    end
                    m_err[k] = 1;
                    if (m_ecnt[k] < 255) m_ecnt[k]++;
                end
                if (m_st[k] == 0) m_st[k] = 1;
                else if (m_st[k] == 1 && e && halt[k] != 0) m_st[k] = 2;
            end
            m_exp[k] = next_q(r, l, c, i, q);
            m_upc[k] = int'(q == 8 && c != 0 && r == 0 && l == 0);
            m_dnc[k] = int'(q == 0 && c == 0 && r == 0 && l == 0);
        end
        cq = next_q(r, l, c, i, q);
    endtask

    task automatic check_all();
        chk("a.synced", a_synced, int'(m_st[0] == 1));
        chk("a.up_wrap", a_up_wrap, m_upp[0]);
        chk("a.dn_wrap", a_dn_wrap, m_dnp[0]);
        chk("a.up_wraps", a_up_wraps, m_upw[0]);
        chk("a.dn_wraps", a_dn_wraps, m_dnw[0]);
        chk("a.err_pulse", a_err_pulse, m_errp[0]);
        chk("a.err", a_err, m_err[0]);
        chk("a.err_cnt", a_err_cnt, m_ecnt[0]);
        chk("a.err_exp", a_err_exp, m_eexp[0]);
        chk("a.err_got", a_err_got, m_egot[0]);
        chk("h.synced", b_synced, int'(m_st[1] == 1));
        chk("h.up_wrap", b_up_wrap, m_upp[1]);
        chk("h.dn_wrap", b_dn_wrap, m_dnp[1]);
        chk("h.up_wraps", b_up_wraps, m_upw[1]);
        chk("h.dn_wraps", b_dn_wraps, m_dnw[1]);
        chk("h.err_pulse", b_err_pulse, m_errp[1]);
        chk("h.err", b_err, m_err[1]);
        chk("h.err_cnt", b_err_cnt, m_ecnt[1]);
        chk("h.err_exp", b_err_exp, m_eexp[1]);
        chk("h.err_got", b_err_got, m_egot[1]);
    endtask

    task automatic step(input bit c, input bit r, input bit l, input bit ctl, input int i,
                        input bit fe, input int fv);
        clr = c; cnt_rst = r; cnt_load = l; cnt_control = ctl; cnt_I = 4'(i);
        cnt_q = fe ? 4'(fv) : 4'(cq);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; cnt_rst = 1'b0; cnt_load = 1'b0; cnt_control = 1'b0;
        cnt_I = 4'd0; cnt_q = 4'd0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // T1: count up 20 cycles from 0
        for (int n = 0; n < 20; n++) step(0, 0, 0, 1, 0, 0, 0);
        chk("t1_up_wraps", a_up_wraps, 2);
        chk("t1_err", a_err, 0);

        // T2: clear, then count down 10 cycles from 0
        step(1, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 10; n++) step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_dn_wraps", a_dn_wraps, 1);
        chk("t2_err", a_err, 0);

        // T3: legal load, ignored load, then a forced bad q
        step(1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 5, 0, 0);
        step(0, 0, 1, 1, 12, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("t3_err_before", a_err, 0);
        step(0, 0, 0, 1, 0, 1, 3);
        chk("t3_err_pulse", a_err_pulse, 1);
        chk("t3_err_exp", a_err_exp, 7);
        chk("t3_err_got", a_err_got, 3);
        chk("t3_err_cnt", a_err_cnt, 1);
        chk("t4_h_synced", b_synced, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("t3_pulse_end", a_err_pulse, 0);

        // T4: second error counted only by the resyncing instance
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t4_a_err_cnt", a_err_cnt, 2);
        chk("t4_h_err_cnt", b_err_cnt, 1);
        step(1, 0, 0, 1, 0, 0, 0);
        chk("t4_h_clr_cnt", b_err_cnt, 0);
        chk("t4_h_clr_sync", b_synced, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("t4_h_track", b_synced, 1);

        // T5: saturation of 2-bit wrap counter, cnt_rst at q=8 is not a wrap
        step(1, 1, 0, 1, 0, 0, 0);
        for (int n = 0; n < 46; n++) step(0, 0, 0, 1, 0, 0, 0);
        chk("t5_a_up_wraps", a_up_wraps, 5);
        chk("t5_h_up_wraps", b_up_wraps, 3);
        for (int n = 0; n < 20 && cq != 8; n++) step(0, 0, 0, 1, 0, 0, 0);
        chk("t5_at_8", cq, 8);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("t5_rst_no_wrap", a_up_wraps, 5);
        chk("t5_rst_no_err", a_err, 0);

        // Randomized traffic with occasional faults and clears
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 15, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), $urandom_range(0, 99) < 6,
                 int'($urandom_range(0, 15)));
        end

        // T6: asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 1'b0, $urandom_range(0, 99) < 10, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
